pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Fetch-side producer of the PC/instruction stream that the per-stage PC pipeline buffers carry towards writeback. Holds the architectural fetch PC and issues single-outstanding requests to instruction memory. Presents {pc, instr} to the IF/ID buffer with a valid/ready handshake. Applies branch/jump redirects from execute, including killing in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_INC, 4, sequential increment in bytes

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
redirect_valid_i  input  1  execute-stage redirect strobe, one cycle
redirect_pc_i  input  32  redirect target
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address, equals current fetch PC
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid, at most one per granted request
imem_rdata_i  input  32  read data
if_valid_o  output  1  {if_pc_o, if_instr_o} valid to IF/ID buffer
if_ready_i  input  1  IF/ID buffer accepts this cycle
if_pc_o  output  32  PC of presented instruction
if_instr_o  output  32  presented instruction
fetch_misalign_o  output  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at posedge): state=IDLE, fetch_pc=RESET_PC, kill=0. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0, fetch_misalign_o=0. rst overrides every other input. A request or response in flight when reset asserts is forgotten. A response arriving after reset is ignored unless the FSM is in WAIT.
- States:
  - IDLE: leaves for REQ in the next cycle.
  - REQ: imem_req_o=1 and imem_addr_o=fetch_pc. Both are held stable until imem_gnt_i=1, then the FSM moves to WAIT.
  - WAIT: on imem_rvalid_i, if kill=1, the data is dropped, kill is cleared, and the FSM goes to REQ. Otherwise the data is captured into if_instr_o, if_pc_o=fetch_pc, and the FSM goes to HOLD.
  - HOLD: if_valid_o=1. When if_ready_i=1, fetch_pc is set to fetch_pc+PC_INC and the FSM goes to REQ. Otherwise the outputs hold.
- Latency: gnt in the same cycle as req and rvalid one cycle later gives if_valid_o 2 cycles after the req cycle. Maximum throughput is 1 instruction per 3 cycles.
- Redirect (redirect_valid_i=1) has priority over sequential update and sets fetch_pc=redirect_pc_i:
  - IDLE or REQ without gnt: the FSM goes to REQ at the new PC next cycle. The withdrawn request is never granted, because the address changes only after the cycle without gnt.
  - REQ with gnt in the same cycle: the FSM goes to WAIT with kill=1.
  - WAIT without rvalid: kill is set to 1.
  - WAIT with rvalid in the same cycle: the response is dropped and the FSM goes to REQ.
  - HOLD: the held instruction is discarded, if_valid_o=0 next cycle, and the FSM goes to REQ. A handshake (if_ready_i=1) in the same cycle is void; the IF/ID buffer flushes on the same redirect.
- Arithmetic: fetch_pc+PC_INC is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Single outstanding request. imem_rvalid_i outside WAIT is ignored.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- With macro: a redirect with redirect_pc_i[1:0]!=0 moves the FSM to a TRAP state. In TRAP:
  - imem_req_o=0, if_valid_o=0, fetch_misalign_o=1.
  - An outstanding response is still absorbed and dropped.
  - TRAP exits only on rst or on an aligned redirect, which clears fetch_misalign_o and goes to REQ.
- Without macro: redirect_pc_i[1:0] are forced to 2'b00 and fetch_misalign_o is tied 0.

Test Plan:
- Reset then free run (gnt same cycle, rvalid +1, if_ready=1) -> imem_addr_o sequence 0x0, 0x4, 0x8. Each if_pc_o matches the instruction returned for its address.
- if_ready_i=0 for 5 cycles in HOLD at pc 0x8 -> if_valid_o, if_pc_o=0x8 and if_instr_o stable. No new imem_req_o until accept.
- Redirect to 0x100 while in WAIT for 0x4 -> returned 0x4 data dropped (no if_valid_o). Next request addr=0x100.
- Redirect to 0x200 in HOLD with if_ready_i=1 in the same cycle -> if_valid_o=0 next cycle. Next request addr=0x200, not 0x4+PC_INC.
- Redirect to 0xFFFF_FFFC, then accept -> next request addr 0x0000_0000.
- rst asserted in WAIT with rvalid arriving in the reset cycle -> all outputs at reset values and first request at RESET_PC. With FETCH_MISALIGN_CHECK_EN, a redirect to 0x102 -> fetch_misalign_o=1 and no req until a redirect to 0x104.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch PC holder: single-outstanding instruction-memory requester feeding the IF/ID buffer.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        fetch_misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        kill_reg, kill_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] redir_pc;
  logic        redir_misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc         = redirect_pc_i;
  assign redir_misalign   = |redirect_pc_i[1:0];
  assign fetch_misalign_o = (state_reg == S_TRAP);
`else
  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^redirect_pc_i[1:0];
  assign redir_pc          = {redirect_pc_i[31:2], 2'b00};
  assign redir_misalign    = 1'b0;
  assign fetch_misalign_o  = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    kill_next     = kill_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ:  if (imem_gnt_i) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_next = 1'b0;
          if (kill_reg) begin
            state_next = S_REQ;
          end else if (!redirect_valid_i) begin
            if_pc_next    = fetch_pc_reg;
            if_instr_next = imem_rdata_i;
            state_next    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (if_ready_i) begin
          fetch_pc_next = fetch_pc_reg + PC_INC;
          state_next    = S_REQ;
        end
      end
      S_TRAP: if (imem_rvalid_i) kill_next = 1'b0;
      default: state_next = S_IDLE;
    endcase

    // kill_next here means "a response is still owed to us after this cycle".
    if (redirect_valid_i) begin
      fetch_pc_next = redir_pc;
      case (state_reg)
        S_REQ:   kill_next = imem_gnt_i;
        S_WAIT:  kill_next = !imem_rvalid_i;
        S_TRAP:  kill_next = kill_reg && !imem_rvalid_i;
        default: kill_next = 1'b0;
      endcase
      // Leaving TRAP with a response still owed drains it in WAIT before re-requesting.
      if (redir_misalign)
        state_next = S_TRAP;
      else if (kill_next)
        state_next = S_WAIT;
      else
        state_next = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      kill_reg     <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_instr_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      kill_reg     <= kill_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
    end
  end

  assign imem_req_o  = (state_reg == S_REQ);
  assign imem_addr_o = fetch_pc_reg;
  assign if_valid_o  = (state_reg == S_HOLD);
  assign if_pc_o     = if_pc_reg;
  assign if_instr_o  = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: bench-side memory and an architectural next-PC model
// check every grant address and every presented {pc, instr}; FETCH_MISALIGN_CHECK_EN adds trap steps.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        fetch_misalign_o;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .fetch_misalign_o(fetch_misalign_o)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int p_gnt = 100, p_ready = 100, p_redir = 0, min_dly = 0, max_dly = 0;
  int hold_rst = 0, arm = 0;   // arm: 1 redirect in WAIT, 2 redirect while presenting, 3 reset on response, 4 redirect now
  logic [31:0] arm_pc = 32'h0;
  bit chk_lat = 0, started = 0;

  // Reference: expected next architectural PC plus the memory's outstanding response.
  logic [31:0] exp_pc = RESET_PC;
  bit          pend = 0, trap = 0;
  int          pend_dly = 0, grant_cyc = 0, idle_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] grants[$];

  bit          l_rst = 0, l_redir = 0, l_req_hold = 0, l_valid_hold = 0, l_valid = 0;
  logic [31:0] l_addr = 0, l_pc = 0, l_instr = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    rst = (hold_rst > 0);
    if (hold_rst > 0) hold_rst--;
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    if_ready_i    = ($urandom_range(99) < p_ready);
    imem_rvalid_i = pend && (pend_dly == 0);
    imem_rdata_i  = imem_rvalid_i ? mem(pend_addr) : $urandom;
    redirect_valid_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_pc_i = $urandom & 32'hFFFF_FFFC;
`else
    redirect_pc_i = $urandom;
`endif
    if ((arm == 1 && pend && !imem_rvalid_i) || (arm == 2 && if_valid_o) || arm == 4) begin
      redirect_valid_i = 1'b1; redirect_pc_i = arm_pc; arm = 0;
    end else if (arm == 3 && imem_rvalid_i) begin
      rst = 1'b1; arm = 0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid_i = 1'b1;
    end
    #1;
    if (started) begin
      if (l_rst) begin
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_valid", if_valid_o, 0);
        chk("rst_pc", if_pc_o, 0);
        chk("rst_instr", if_instr_o, 0);
        chk("rst_misalign", fetch_misalign_o, 0);
      end else begin
        if (l_req_hold) begin
          chk("req_stable", imem_req_o, 1);
          chk("addr_stable", imem_addr_o, l_addr);
        end
        if (l_valid_hold) begin
          chk("hold_valid", if_valid_o, 1);
          chk("hold_pc", if_pc_o, l_pc);
          chk("hold_instr", if_instr_o, l_instr);
        end
        if (l_redir) chk("valid_after_redirect", if_valid_o, 0);
      end
      if (pend) chk("single_outstanding", imem_req_o, 0);
      if (imem_req_o && imem_gnt_i) chk("req_addr", imem_addr_o, exp_pc);
      if (if_valid_o) begin
        chk("if_pc", if_pc_o, exp_pc);
        chk("if_instr", if_instr_o, mem(exp_pc));
        chk("no_req_in_hold", imem_req_o, 0);
        if (chk_lat && !l_valid) chk("latency", cyc - grant_cyc, 2);
      end
      chk("misalign", fetch_misalign_o, trap);
      if (trap) begin
        chk("trap_req", imem_req_o, 0);
        chk("trap_valid", if_valid_o, 0);
      end
      chk("progress", idle_cnt > 40, 0);
    end
    if (rst) started = 1;

    l_rst        = rst;
    l_redir      = redirect_valid_i && !rst;
    l_req_hold   = imem_req_o && !imem_gnt_i && !redirect_valid_i && !rst;
    l_addr       = imem_addr_o;
    l_valid_hold = if_valid_o && !if_ready_i && !redirect_valid_i && !rst;
    l_pc         = if_pc_o;
    l_instr      = if_instr_o;
    l_valid      = if_valid_o;
    if (rst) begin
      exp_pc = RESET_PC; pend = 0; trap = 0; idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (imem_rvalid_i) pend = 0;
      else if (pend) pend_dly--;
      if (imem_req_o && imem_gnt_i) begin
        grants.push_back(imem_addr_o);
        grant_cyc = cyc;
        pend = 1; pend_dly = $urandom_range(max_dly, min_dly); pend_addr = imem_addr_o;
      end
      if (redirect_valid_i) begin
        idle_cnt = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc_i[1:0] != 2'b00) trap = 1;
        else begin trap = 0; exp_pc = redirect_pc_i; end
`else
        exp_pc = {redirect_pc_i[31:2], 2'b00};
`endif
      end else if (if_valid_o && if_ready_i) begin
        exp_pc = exp_pc + 32'd4;
        idle_cnt = 0;
      end
    end
  endtask

  task automatic run_to_grant(input int max);
    int n0 = grants.size();
    int i = 0;
    while (grants.size() == n0 && i < max) begin step(); i++; end
    chk("grant_timeout", grants.size() > n0, 1);
  endtask

  initial begin
    hold_rst = 2;
    step(); step();

    // Free run: sequential addresses and 2-cycle req-to-valid latency.
    chk_lat = 1;
    for (int i = 0; i < 40 && grants.size() < 3; i++) step();
    chk("grant_count", grants.size(), 3);
    for (int i = 0; i < 3; i++) if (grants.size() > i) chk("seq_addr", grants[i], 4 * i);
    p_ready = 0;
    for (int i = 0; i < 8; i++) step();
    chk("stall_valid", if_valid_o, 1);
    chk("stall_pc", if_pc_o, 32'h8);
    chk("stall_no_req", imem_req_o, 0);
    p_ready = 100; chk_lat = 0;

    // Redirect while waiting on the 0x4 response.
    hold_rst = 1; step();
    min_dly = 2; max_dly = 2;
    for (int i = 0; i < 20 && (grants.size() == 0 || grants[$] != 32'h4); i++) step();
    chk("reach_wait_4", grants[$], 32'h4);
    arm = 1; arm_pc = 32'h100;
    run_to_grant(30);
    chk("redir_wait_addr", grants[$], 32'h100);

    // Redirect in HOLD with a simultaneous handshake.
    arm = 2; arm_pc = 32'h200;
    run_to_grant(30);
    chk("redir_hold_addr", grants[$], 32'h200);

    // Wrap-around of the sequential increment.
    arm = 2; arm_pc = 32'hFFFF_FFFC;
    run_to_grant(30);
    chk("wrap_pre", grants[$], 32'hFFFF_FFFC);
    run_to_grant(30);
    chk("wrap_post", grants[$], 32'h0);

    // Reset in WAIT with the response arriving in the reset cycle.
    min_dly = 1; max_dly = 1; arm = 3;
    for (int i = 0; i < 20 && arm == 3; i++) step();
    chk("rst_fired", arm, 0);
    run_to_grant(30);
    chk("rst_first_addr", grants[$], RESET_PC);

`ifdef FETCH_MISALIGN_CHECK_EN
    arm = 2; arm_pc = 32'h102;
    for (int i = 0; i < 20 && arm == 2; i++) step();
    for (int i = 0; i < 6; i++) step();
    chk("trap_flag", fetch_misalign_o, 1);
    arm = 4; arm_pc = 32'h104;
    run_to_grant(30);
    chk("trap_exit_addr", grants[$], 32'h104);
`endif

    // Randomized traffic.
    p_gnt = 70; p_ready = 60; p_redir = 4; min_dly = 0; max_dly = 3;
    for (int i = 0; i < 2000; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
